// File: rtl/mul_hilo_if.sv
// mul_hilo_if: datapath-facing bundle of the HI/LO multiply unit.
//   start, op_signed, rs_val, rt_val : multiply request and its operands
//   mthi, mtlo, wdata                : direct HI/LO writes
//   busy, done                       : pipeline stall and completion pulse
//   hi, lo                           : architectural HI/LO registers
// Modports: master = datapath/pipeline side, slave = mul_hilo_unit.
interface mul_hilo_if;
  logic        start;
  logic        op_signed;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op_signed, rs_val, rt_val, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op_signed, rs_val, rt_val, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit: sequencer and HI/LO result store around the registered
// 32x32 multiplier mul_int.
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : mul_hilo_if.slave (request, direct writes, busy/done, hi/lo)
//   mul_a, mul_b : registered operands to mul_int (held between requests)
//   mul_c        : 64-bit product from mul_int, valid MUL_LAT edges after
//                  mul_a/mul_b settle
// Parameter MUL_LAT (1..15): multiplier latency in clock edges.
// Optional feature: define MUL_SIGNED_EN to enable signed multiply
// (magnitudes into mul_int, sign applied to the product at capture).
module mul_hilo_unit #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  mul_hilo_if.slave   bus,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_c
);

  typedef enum logic [1:0] {IDLE, WAIT, CAPT} state_t;

  localparam logic [3:0] LAT = 4'(MUL_LAT);

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        busy_q, done_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] a_in, b_in;
  logic [63:0] product;

`ifdef MUL_SIGNED_EN
  logic neg;

  // mul_int is unsigned: feed it magnitudes and fix the sign on capture.
  // 0x80000000 negates to itself, which is the right unsigned magnitude.
  assign a_in    = (bus.op_signed && bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
  assign b_in    = (bus.op_signed && bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;
  assign product = neg ? (~mul_c + 64'd1) : mul_c;

  always_ff @(posedge clk) begin
    if (!rst_n)
      neg <= 1'b0;
    else if (state == IDLE && bus.start)
      neg <= bus.op_signed & (bus.rs_val[31] ^ bus.rt_val[31]);
  end
`else
  logic unused_op_signed;

  assign unused_op_signed = bus.op_signed;
  assign a_in             = bus.rs_val;
  assign b_in             = bus.rt_val;
  assign product          = mul_c;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = WAIT;
      WAIT:    if (cnt == 4'd1) state_next = CAPT;  // reaches 0 at this edge
      CAPT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; HI/LO are plain registers and are reset like the rest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      mul_a  <= 32'd0;
      mul_b  <= 32'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
      done_q <= (state == CAPT);
      case (state)
        IDLE: begin
          if (bus.start) begin
            mul_a <= a_in;
            mul_b <= b_in;
            cnt   <= LAT;
          end
          // Direct writes only land in IDLE; a product issued on the same
          // edge overwrites both halves later.
          if (bus.mthi) hi_q <= bus.wdata;
          if (bus.mtlo) lo_q <= bus.wdata;
        end
        WAIT:    cnt <= cnt - 4'd1;
        CAPT:    {hi_q, lo_q} <= product;
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
module tb_mul_hilo_unit;
  localparam int MUL_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_c;

  mul_hilo_if bus ();

  mul_hilo_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_c (mul_c)
  );

  always #5 clk = ~clk;

  // Stand-in for mul_int: one registered stage, unsigned 32x32 -> 64.
  always_ff @(posedge clk) mul_c <= {32'd0, mul_a} * {32'd0, mul_b};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  logic [63:0] sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] rs, input logic [31:0] rt,
                                        input logic sgn);
    logic [63:0] ea, eb;
    ea = {32'd0, rs};
    eb = {32'd0, rt};
`ifdef MUL_SIGNED_EN
    if (sgn) begin
      ea = {{32{rs[31]}}, rs};
      eb = {{32{rt[31]}}, rt};
    end
`else
    if (sgn) ea = {32'd0, rs};  // signed requests behave as unsigned
`endif
    return ea * eb;
  endfunction

  // Scoreboard side: every done pops one expected product.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      logic [63:0] exp;
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", {63'd0, bus.done}, 64'd0);
      end else begin
        exp = sb.pop_front();
        check("hi", {32'd0, bus.hi}, {32'd0, exp[63:32]});
        check("lo", {32'd0, bus.lo}, {32'd0, exp[31:0]});
      end
    end
  end

  // poke: 0 none, 1 mtlo 0xAAAA during WAIT, 2 second start during WAIT
  task automatic do_mul(input logic [31:0] rs, input logic [31:0] rt,
                        input logic sgn, input int poke);
    int n;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.rs_val    = rs;
    bus.rt_val    = rt;
    bus.op_signed = sgn;
    sb.push_back(model(rs, rt, sgn));
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
    if (poke == 1) begin
      bus.mtlo  = 1'b1;
      bus.wdata = 32'h0000_AAAA;
    end
    if (poke == 2) begin
      bus.start  = 1'b1;
      bus.rs_val = 32'd100;
      bus.rt_val = 32'd100;
    end
    n = 1;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      bus.mtlo  = 1'b0;
      bus.start = 1'b0;
      n++;
    end
    check("done_latency", 64'(n), 64'(MUL_LAT + 2));
    check("busy_at_done", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    check("done_one_cycle", {63'd0, bus.done}, 64'd0);
    check("idle_after_done", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int exp_done;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.op_signed = 1'b0;
    bus.rs_val    = 32'd0;
    bus.rt_val    = 32'd0;
    bus.mthi      = 1'b0;
    bus.mtlo      = 1'b0;
    bus.wdata     = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_hi",    {32'd0, bus.hi}, 64'd0);
    check("rst_lo",    {32'd0, bus.lo}, 64'd0);
    check("rst_mul_a", {32'd0, mul_a},  64'd0);
    check("rst_mul_b", {32'd0, mul_b},  64'd0);
    check("rst_busy",  {63'd0, bus.busy}, 64'd0);
    check("rst_done",  {63'd0, bus.done}, 64'd0);

    // Unsigned full-scale product.
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    check("mul_a_held", {32'd0, mul_a}, 64'h0000_0000_FFFF_FFFF);
    check("full_scale", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

    // -1 * 3: signed when enabled, unsigned otherwise.
    do_mul(32'hFFFF_FFFF, 32'd3, 1'b1, 0);
`ifdef MUL_SIGNED_EN
    check("neg1_x3", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    check("neg1_x3", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFD);
`endif
    do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    do_mul(32'h8000_0000, 32'd7, 1'b1, 0);

    // Direct HI write in IDLE, then a product with mtlo poked during WAIT.
    @(negedge clk);
    bus.mthi  = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.mthi = 1'b0;
    check("mthi_idle", {32'd0, bus.hi}, 64'h1234);
    do_mul(32'd5, 32'd7, 1'b0, 1);
    check("mtlo_dropped", {bus.hi, bus.lo}, 64'd35);

    // start while busy is ignored: one done, first operands' result.
    exp_done = n_done + 1;
    do_mul(32'd11, 32'd13, 1'b0, 2);
    repeat (4) @(negedge clk);
    check("single_done", 64'(n_done), 64'(exp_done));
    check("busy_start_result", {bus.hi, bus.lo}, 64'd143);

    // start together with mthi/mtlo: direct write lands, product overwrites it.
    @(negedge clk);
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h5555_5555;
    bus.start = 1'b1;
    bus.rs_val = 32'd9;
    bus.rt_val = 32'd9;
    bus.op_signed = 1'b0;
    sb.push_back(64'd81);
    @(negedge clk);
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.start = 1'b0;
    check("combined_write_hi", {32'd0, bus.hi}, 64'h5555_5555);
    repeat (4) @(negedge clk);
    check("combined_final", {bus.hi, bus.lo}, 64'd81);

    // A handful of random operations.
    for (int i = 0; i < 6; i++)
      do_mul($urandom, $urandom, 1'($urandom_range(0, 1)), 0);

    // Reset in WAIT: product discarded, no done, HI/LO cleared.
    exp_done = n_done;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.rs_val = 32'd2;
    bus.rt_val = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", 64'(n_done), 64'(exp_done));
    check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mul_hilo_unit.md
# mul_hilo_unit

Sequencer and result store wrapped around the 32x32 unsigned multiplier `mul_int`. It accepts a multiply request from the datapath and drives the operands into `mul_int`. It waits out the multiplier's registered latency, then writes the 64-bit product into architectural HI/LO registers. It also services direct HI/LO writes and reports a busy stall to the pipeline.

## Interface
Parameters:
- `MUL_LAT`, default 1: clock edges from `mul_a`/`mul_b` becoming stable to `mul_c` valid. Legal range is 1..15; `mul_int` as built is 1.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: multiply request; sampled only in IDLE.
- `op_signed` in 1: 1 = signed multiply (mult), 0 = unsigned (multu). Only meaningful when `MUL_SIGNED_EN` is defined.
- `rs_val` in 32: multiplicand, sampled with `start`.
- `rt_val` in 32: multiplier, sampled with `start`.
- `mthi` in 1: write `wdata` to HI.
- `mtlo` in 1: write `wdata` to LO.
- `wdata` in 32: data for `mthi`/`mtlo`.
- `mul_a` out 32: registered operand to `mul_int.a`.
- `mul_b` out 32: registered operand to `mul_int.b`.
- `mul_c` in 64: product from `mul_int.c`.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse on the cycle HI/LO first shows a new product.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, WAIT, CAPT.
- IDLE → WAIT on `start`:
  - latch `mul_a` and `mul_b` (magnitudes when signed, see Configuration);
  - latch the result sign flag;
  - load the wait counter with `MUL_LAT`.
- WAIT: decrement the counter each edge. On the edge where it reaches 0, go to CAPT.
- CAPT, one cycle:
  - on the next edge, `{hi,lo} <= mul_c` (sign-corrected if required);
  - assert `done` for the following cycle;
  - return to IDLE.
- `mul_a`/`mul_b` hold their value outside of `start`. The multiplier input is therefore stable for the whole operation.
- `mthi`/`mtlo` are honoured only in IDLE. When busy they are dropped; the pipeline must stall on `busy`.
- `start` together with `mthi`/`mtlo` in IDLE: the direct write happens at that edge, and the product later overwrites both HI and LO.
- `start` while busy is ignored.
- Arithmetic: product is exactly 64 bits with no truncation. For unsigned, `0xFFFFFFFF * 0xFFFFFFFF = 0xFFFFFFFE_00000001`.

## Timing
- Reset values: state IDLE; `mul_a`, `mul_b`, `hi`, `lo` = 0; `busy` = 0; `done` = 0.
- `start` sampled at edge N:
  - `busy` is high from after N until after edge N+1+`MUL_LAT`;
  - HI/LO are updated at edge N+1+`MUL_LAT`;
  - `done` is high for exactly the cycle after that edge.
- With `MUL_LAT` = 1: HI/LO are written at N+2, and a new `start` is accepted at N+3. Back-to-back issue period is `MUL_LAT`+2 cycles.
- Reset mid-operation: reset wins at that edge. The in-flight product is discarded and never written, HI/LO clear to 0, and no `done` is produced.
- `busy` and `done` are registered outputs with no combinational path from inputs.

## Configuration
- Macro `MUL_SIGNED_EN`.
- Defined:
  - when `op_signed`=1, `mul_a`/`mul_b` receive the two's-complement magnitudes of `rs_val`/`rt_val`;
  - the sign flag is `rs_val[31] ^ rt_val[31]`;
  - in CAPT, if the flag is set, the 64-bit `mul_c` is negated before writing;
  - `0x80000000` magnitude stays `0x80000000`, which is correct as unsigned.
- Not defined: `op_signed` is ignored, operands pass through unchanged, and all multiplies are unsigned.

## Test plan
- Reset then idle: `hi`, `lo`, `mul_a`, `mul_b` = 0; `busy` = `done` = 0.
- Unsigned: `start`, `rs`=`0xFFFFFFFF`, `rt`=`0xFFFFFFFF` → `hi`=`0xFFFFFFFE`, `lo`=`0x00000001` at edge N+2; `done` pulses one cycle; `busy` covers N+1..N+2.
- Signed (macro on): `rs`=`0xFFFFFFFF` (-1), `rt`=3 → `hi`=`0xFFFFFFFF`, `lo`=`0xFFFFFFFD`. Same inputs with macro off → `hi`=2, `lo`=`0xFFFFFFFD`.
- `mthi` `wdata`=`0x1234` in IDLE → `hi`=`0x1234` next cycle. Then `start` 5*7 with `mtlo`=`0xAAAA` asserted in WAIT → `mtlo` dropped; final `hi`=0, `lo`=35.
- `start` again while busy → ignored; only one `done`, result from the first operands.
- `rst_n`=0 in WAIT after `start` of 2*2 → no `done`; `hi`=`lo`=0 afterwards.
